// File: rtl/xf100_exu_wbck_arb_pkg.sv
// Shared constants and types for the EXU writeback arbiter.
package xf100_exu_wbck_arb_pkg;

  localparam int unsigned WBCK_XLEN       = 32;
  localparam int unsigned WBCK_RFIDX_W    = 5;
  localparam int unsigned WBCK_STARVE_MAX = 3;
  localparam int unsigned WBCK_CNT_W      = 2;

  typedef enum logic [1:0] {
    GntNone,
    GntAlu,
    GntLng
  } wbck_gnt_e;

endpackage

// File: rtl/xf100_exu_wbck_arb.sv
// Two-source regfile writeback arbiter: long pipe wins by default, a saturating
// starvation counter forces an ALU grant; registered output, x0 writes squashed.
module xf100_exu_wbck_arb
  import xf100_exu_wbck_arb_pkg::*;
#(
  parameter int unsigned XLEN       = WBCK_XLEN,
  parameter int unsigned RFIDX_W    = WBCK_RFIDX_W,
  parameter int unsigned STARVE_MAX = WBCK_STARVE_MAX,
  parameter int unsigned CNT_W      = WBCK_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arb_i_alu_valid,
  output logic               arb_o_alu_ready,
  input  logic [XLEN-1:0]    arb_i_alu_data,
  input  logic [RFIDX_W-1:0] arb_i_alu_rdidx,
  input  logic               arb_i_lng_valid,
  output logic               arb_o_lng_ready,
  input  logic [XLEN-1:0]    arb_i_lng_data,
  input  logic [RFIDX_W-1:0] arb_i_lng_rdidx,
  output logic               arb_o_wbck_en,
  output logic [XLEN-1:0]    arb_o_wbck_data,
  output logic [RFIDX_W-1:0] arb_o_wbck_rdidx,
  output logic               arb_o_alu_starved
);

  localparam logic [CNT_W-1:0] StarveMaxC = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_force_alu;
  logic             w_lng_ready;
  logic             w_alu_ready;
  wbck_gnt_e        w_gnt;

  assign w_force_alu = (r_cnt == StarveMaxC);
  assign w_lng_ready = ~rst & arb_i_lng_valid & ~(w_force_alu & arb_i_alu_valid);
  assign w_alu_ready = ~rst & arb_i_alu_valid & ~w_lng_ready;

  assign arb_o_alu_ready = w_alu_ready;
  assign arb_o_lng_ready = w_lng_ready;

  always_comb begin
    w_gnt = GntNone;
    if (w_lng_ready) begin
      w_gnt = GntLng;
    end else if (w_alu_ready) begin
      w_gnt = GntAlu;
    end
  end

  // Counts consecutive cycles the ALU is refused; any cycle without a blocked
  // ALU request clears it.
  always_comb begin
    w_cnt_nxt = '0;
    if (arb_i_alu_valid && !w_alu_ready) begin
      w_cnt_nxt = w_force_alu ? r_cnt : r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt             <= '0;
      arb_o_alu_starved <= 1'b0;
    end else begin
      r_cnt             <= w_cnt_nxt;
      arb_o_alu_starved <= (w_cnt_nxt == StarveMaxC);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arb_o_wbck_en    <= 1'b0;
      arb_o_wbck_data  <= '0;
      arb_o_wbck_rdidx <= '0;
    end else begin
      case (w_gnt)
        GntLng: begin
          arb_o_wbck_en    <= |arb_i_lng_rdidx;
          arb_o_wbck_data  <= arb_i_lng_data;
          arb_o_wbck_rdidx <= arb_i_lng_rdidx;
        end
        GntAlu: begin
          arb_o_wbck_en    <= |arb_i_alu_rdidx;
          arb_o_wbck_data  <= arb_i_alu_data;
          arb_o_wbck_rdidx <= arb_i_alu_rdidx;
        end
        default: arb_o_wbck_en <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_xf100_exu_wbck_arb.sv
// Bench for the writeback arbiter: directed literal checks plus randomized
// traffic compared every cycle against a behavioural model.
module tb_xf100_exu_wbck_arb;

  localparam int SMAX = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lng_valid;
  logic [31:0] alu_data, lng_data;
  logic [4:0]  alu_idx, lng_idx;
  logic        alu_ready, lng_ready;
  logic        wb_en;
  logic [31:0] wb_data;
  logic [4:0]  wb_idx;
  logic        starved;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // Model state: how many cycles in a row the ALU has been refused, and the
  // write that should currently be on the regfile port.
  int          m_wait = 0;
  logic        m_en = 1'b0;
  logic [31:0] m_data = '0;
  logic [4:0]  m_idx = '0;
  logic        m_starved = 1'b0;

  always #5 clk = ~clk;

  xf100_exu_wbck_arb dut (
    .clk               (clk),
    .rst               (rst),
    .arb_i_alu_valid   (alu_valid),
    .arb_o_alu_ready   (alu_ready),
    .arb_i_alu_data    (alu_data),
    .arb_i_alu_rdidx   (alu_idx),
    .arb_i_lng_valid   (lng_valid),
    .arb_o_lng_ready   (lng_ready),
    .arb_i_lng_data    (lng_data),
    .arb_i_lng_rdidx   (lng_idx),
    .arb_o_wbck_en     (wb_en),
    .arb_o_wbck_data   (wb_data),
    .arb_o_wbck_rdidx  (wb_idx),
    .arb_o_alu_starved (starved)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Long pipe is served whenever it asks, unless the ALU has already been
  // refused SMAX times in a row and is still asking.
  function automatic void model_grant(output logic ga, output logic gl);
    if (rst) begin
      ga = 1'b0;
      gl = 1'b0;
    end else begin
      gl = lng_valid && !(alu_valid && m_wait >= SMAX);
      ga = alu_valid && !gl;
    end
  endfunction

  always @(posedge clk) begin
    logic ga, gl;
    model_grant(ga, gl);
    if (rst) begin
      m_wait = 0; m_en = 1'b0; m_data = '0; m_idx = '0; m_starved = 1'b0;
    end else begin
      if (gl) begin
        m_en = (lng_idx != 0); m_data = lng_data; m_idx = lng_idx;
      end else if (ga) begin
        m_en = (alu_idx != 0); m_data = alu_data; m_idx = alu_idx;
      end else begin
        m_en = 1'b0;
      end
      if (alu_valid && !ga) m_wait = (m_wait + 1 > SMAX) ? SMAX : m_wait + 1;
      else                  m_wait = 0;
      m_starved = (m_wait == SMAX);
    end
  end

  always @(negedge clk) begin
    logic ga, gl;
    if (chk_on) begin
      model_grant(ga, gl);
      chk("alu_ready", 32'(alu_ready), 32'(ga));
      chk("lng_ready", 32'(lng_ready), 32'(gl));
      chk("wbck_en", 32'(wb_en), 32'(m_en));
      chk("wbck_data", wb_data, m_data);
      chk("wbck_rdidx", 32'(wb_idx), 32'(m_idx));
      chk("alu_starved", 32'(starved), 32'(m_starved));
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic ga_s, gl_s;
    rst = 1'b1;
    alu_valid = 1'b1; alu_data = 32'h1234; alu_idx = 5'd9;
    lng_valid = 1'b1; lng_data = 32'h5678; lng_idx = 5'd10;
    nxt();
    chk_on = 1'b1;

    // Reset held with both requesting.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_alu_ready", 32'(alu_ready), 32'd0);
      chk("rst_lng_ready", 32'(lng_ready), 32'd0);
      chk("rst_wbck_en", 32'(wb_en), 32'd0);
      chk("rst_wbck_data", wb_data, 32'd0);
      chk("rst_starved", 32'(starved), 32'd0);
    end

    // ALU only.
    nxt();
    rst = 1'b0;
    alu_valid = 1'b1; alu_idx = 5'd5; alu_data = 32'h100;
    lng_valid = 1'b0;
    @(negedge clk);
    chk("alu_only_ready", 32'(alu_ready), 32'd1);

    // x0 write from the long pipe.
    nxt();
    alu_valid = 1'b0;
    lng_valid = 1'b1; lng_idx = 5'd0; lng_data = 32'hDEAD;
    @(negedge clk);
    chk("alu_only_en", 32'(wb_en), 32'd1);
    chk("alu_only_idx", 32'(wb_idx), 32'd5);
    chk("alu_only_data", wb_data, 32'h100);
    chk("x0_lng_ready", 32'(lng_ready), 32'd1);

    // Both requesting: long pipe wins three times, then the ALU is forced.
    nxt();
    alu_valid = 1'b1; alu_idx = 5'd3; alu_data = 32'hA;
    lng_valid = 1'b1; lng_idx = 5'd4; lng_data = 32'hB;
    @(negedge clk);
    chk("x0_en", 32'(wb_en), 32'd0);
    chk("x0_idx", 32'(wb_idx), 32'd0);
    chk("x0_data", wb_data, 32'hDEAD);
    chk("starve_c0_lng", 32'(lng_ready), 32'd1);
    chk("starve_c0_starved", 32'(starved), 32'd0);
    for (int c = 1; c < 3; c++) begin
      nxt();
      @(negedge clk);
      chk("starve_lng_ready", 32'(lng_ready), 32'd1);
      chk("starve_alu_ready", 32'(alu_ready), 32'd0);
    end
    nxt();
    @(negedge clk);
    chk("starve_c3_starved", 32'(starved), 32'd1);
    chk("starve_c3_alu", 32'(alu_ready), 32'd1);
    chk("starve_c3_lng", 32'(lng_ready), 32'd0);
    nxt();
    @(negedge clk);
    chk("starve_c4_lng", 32'(lng_ready), 32'd1);
    chk("starve_c4_starved", 32'(starved), 32'd0);
    chk("starve_c4_idx", 32'(wb_idx), 32'd3);
    chk("starve_c4_data", wb_data, 32'hA);
    nxt();
    @(negedge clk);
    chk("starve_c5_lng", 32'(lng_ready), 32'd1);

    // Back-to-back alternating sources.
    nxt();
    for (int i = 0; i < 4; i++) begin
      alu_valid = (i % 2 == 0); alu_idx = 5'd1; alu_data = 32'h11;
      lng_valid = (i % 2 == 1); lng_idx = 5'd2; lng_data = 32'h22;
      @(negedge clk);
      chk("b2b_ready", 32'((i % 2 == 0) ? alu_ready : lng_ready), 32'd1);
      if (i > 0) begin
        chk("b2b_en", 32'(wb_en), 32'd1);
        chk("b2b_idx", 32'(wb_idx), (i % 2 == 1) ? 32'd1 : 32'd2);
      end
      nxt();
    end
    alu_valid = 1'b0; lng_valid = 1'b0;
    @(negedge clk);
    chk("b2b_last_en", 32'(wb_en), 32'd1);
    chk("b2b_last_data", wb_data, 32'h22);

    // Reset right after a long-pipe transfer.
    nxt();
    lng_valid = 1'b1; lng_idx = 5'd7; lng_data = 32'h77;
    @(negedge clk);
    chk("mid_rst_lng_ready", 32'(lng_ready), 32'd1);
    nxt();
    lng_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_pre_en", 32'(wb_en), 32'd1);
    chk("mid_rst_pre_idx", 32'(wb_idx), 32'd7);
    nxt();
    @(negedge clk);
    chk("mid_rst_en", 32'(wb_en), 32'd0);
    chk("mid_rst_idx", 32'(wb_idx), 32'd0);
    chk("mid_rst_starved", 32'(starved), 32'd0);
    nxt();
    rst = 1'b0;

    // Randomized traffic; requesters hold their payload until granted.
    ga_s = 1'b0; gl_s = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!(alu_valid && !ga_s)) begin
        alu_valid = ($urandom_range(0, 3) != 0);
        alu_data  = $urandom;
        alu_idx   = 5'($urandom_range(0, 31));
      end
      if (!(lng_valid && !gl_s)) begin
        lng_valid = ($urandom_range(0, 2) != 0);
        lng_data  = $urandom;
        lng_idx   = 5'($urandom_range(0, 31));
      end
      rst = ($urandom_range(0, 63) == 0);
      @(negedge clk);
      ga_s = alu_ready;
      gl_s = lng_ready;
      nxt();
    end

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xf100_exu_wbck_arb.md
Name: xf100_exu_wbck_arb

Overview:
- Arbitrates two writeback sources onto the single regfile write port: the single-cycle ALU pipe and the long-latency pipe (AGU/LSU, later MULDIV).
- Sits between the execution pipes and the regfile write port, in the slot currently filled by the pass-through writeback stage.
- The long pipe has default priority. A saturating starvation counter forces an ALU grant after a bounded wait.
- Output is registered, giving one cycle of latency. Writes to x0 are accepted and then squashed.

Parameters:
- XLEN, 32, data width (`XF100_XLEN)
- RFIDX_W, 5, register index width (`XF100_RFIDX_WIDTH)
- STARVE_MAX, 3, consecutive ALU-blocked cycles before the ALU is forced to win; legal range is 1..2^CNT_W-1
- CNT_W, 2, starvation counter width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- arb_i_alu_valid  in  1  ALU writeback request
- arb_o_alu_ready  out  1  ALU request granted this cycle
- arb_i_alu_data  in  XLEN  ALU result
- arb_i_alu_rdidx  in  RFIDX_W  ALU destination register index
- arb_i_lng_valid  in  1  long-pipe writeback request
- arb_o_lng_ready  out  1  long-pipe request granted this cycle
- arb_i_lng_data  in  XLEN  long-pipe result
- arb_i_lng_rdidx  in  RFIDX_W  long-pipe destination register index
- arb_o_wbck_en  out  1  regfile write enable (registered)
- arb_o_wbck_data  out  XLEN  regfile write data (registered)
- arb_o_wbck_rdidx  out  RFIDX_W  regfile write index (registered)
- arb_o_alu_starved  out  1  high while the counter equals STARVE_MAX (registered)

Behaviour:
- Reset (rst=1 at an edge):
  - starve_cnt=0; arb_o_wbck_en=0, arb_o_wbck_data=0, arb_o_wbck_rdidx=0; arb_o_alu_starved=0.
  - While rst=1, both readys are forced to 0, so no transfer occurs.
  - Reset asserted mid-stream drops the in-flight registered write. Requesters keep valid asserted and are served after reset deasserts.
- Grant (combinational from the valids and the registered counter):
  - force_alu = (starve_cnt==STARVE_MAX).
  - lng_ready = lng_valid & ~(force_alu & alu_valid).
  - alu_ready = alu_valid & ~lng_ready.
  - At most one ready is high in any cycle. Neither ready is high when its own valid is low.
- Transfer: a transfer happens when valid&ready on a side. The selected data and rdidx are captured into the output registers at that edge.
- Output, the cycle after a transfer:
  - arb_o_wbck_en = 1 if the captured rdidx != 0, else 0 (x0 squash; data/rdidx still updated).
  - With no transfer, arb_o_wbck_en=0 and data/rdidx hold their previous values.
  - Throughput is one write per cycle with no bubbles.
- Starvation counter, per edge:
  - ALU transfer → 0.
  - alu_valid & ~alu_ready → min(cnt+1, STARVE_MAX).
  - alu_valid=0 → 0.
  - arb_o_alu_starved is registered as (next cnt == STARVE_MAX).
  - Guarantee: an ALU request waits at most STARVE_MAX cycles before it is granted.
- Simultaneous events:
  - Both valid with cnt<STARVE_MAX → long pipe wins.
  - Both valid with cnt==STARVE_MAX → ALU wins. The long pipe stalls exactly one cycle, and the counter then clears.
  - Same rdidx from both sources on consecutive cycles → the writes occur in grant order; no merging.
- Protocol (requester obligation, asserted by the bench): once valid is high, valid/data/rdidx stay stable until ready. The arbiter does not depend on this for safety, but the starvation bound assumes it.
- No internal FIFO; back-pressure goes only through ready.

Decomposition:
- Shared defines header (xf100_defines.v): add `XF100_WBCK_STARVE_MAX (3) and `XF100_WBCK_CNT_W (2); reuse `XF100_XLEN and `XF100_RFIDX_WIDTH.
- No sub-module needed. The starvation counter and output register are inline always blocks (one for the counter, one for the output stage).
- The block replaces the existing writeback stage instance in xf100_exu. The ALU writeback outputs drive the ALU request; the long-pipe request is tied to 0 until the AGU exists.

Test Plan:
- Reset: hold rst=1 for 3 cycles with both valid=1 → both readys 0, wbck_en=0, wbck_data=0, starved=0 throughout.
- ALU only: alu_valid=1, rdidx=5, data=0x100 → alu_ready=1 the same cycle; next cycle wbck_en=1, rdidx=5, data=0x100.
- x0 squash: lng_valid=1, rdidx=0, data=0xDEAD → lng_ready=1; next cycle wbck_en=0, rdidx=0.
- Both valid for 6 cycles (STARVE_MAX=3):
  - Cycles 0–2: lng_ready=1, starve_cnt 1,2,3.
  - Cycle 3: starved=1, alu_ready=1, lng_ready=0.
  - Cycle 4: cnt=0, long pipe wins again.
- Back-to-back: alternate ALU rdidx=1 data=0x11 and lng rdidx=2 data=0x22 for 4 cycles → 4 consecutive wbck_en=1 cycles, in grant order, with no bubble.
- Mid-operation reset: assert rst in the cycle after a lng transfer (rdidx=7) → wbck_en=0 at the next edge, the write is lost, cnt=0.
